sbox_pipe_sched: RTL and testbench

Scheduler for the shared, fully pipelined first-order masked S-box (the GF(2^4) sq-sc-mul first stage plus later stages). It arbitrates issue slots between the state-byte requester (ST, 16 bytes per round) and the key-schedule requester (KS, 4 bytes per round). Each issue is gated on fresh-mask availability from the PRNG. A tag pipeline matched to the S-box latency marks which source and byte index each S-box output belongs to.

---
 rtl/sbox_pipe_sched.sv | 160 ++++++++++++++++
 tb/tb_sbox_pipe_sched.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_pipe_sched.sv
// Issue scheduler for the shared masked S-box: round-robin between the state-byte
// (ST) and key-schedule (KS) requesters, gated on PRNG masks, with a tag pipe for retirement.
module sbox_pipe_sched #(
  parameter int SBOX_LAT = 4,
  parameter int ST_BYTES = 16,
  parameter int KS_BYTES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       flush,
  input  logic       st_start,
  output logic       st_busy,
  output logic       st_done,
  input  logic       ks_start,
  output logic       ks_busy,
  output logic       ks_done,
  input  logic       rnd_valid,
  output logic       rnd_ready,
  output logic       sb_in_valid,
  output logic       sb_in_src,
  output logic [4:0] sb_in_idx,
  output logic       sb_out_valid,
  output logic       sb_out_src,
  output logic [4:0] sb_out_idx
);

  localparam int IW = $clog2(SBOX_LAT + 1);
  localparam logic [4:0] LAST_IDX [2] = '{5'(ST_BYTES - 1), 5'(KS_BYTES - 1)};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} src_state_e;

  // Index 0 is ST, index 1 is KS throughout.
  src_state_e    state_q [2];
  src_state_e    state_d [2];
  logic [4:0]    cnt_q   [2];
  logic [4:0]    cnt_d   [2];
  logic [IW-1:0] infl_q  [2];
  logic [IW-1:0] infl_d  [2];
  logic [1:0]    done_q, done_d;
  logic [1:0]    start, elig, gnt, retire;
  logic          rr_last_q, rr_last_d;

  logic          tag_v_q   [SBOX_LAT];
  logic          tag_src_q [SBOX_LAT];
  logic [4:0]    tag_idx_q [SBOX_LAT];

  assign start = {ks_start, st_start};

  // rr_last_q holds the source granted most recently; reset value ST makes KS win first.
  always_comb begin
    elig      = 2'b00;
    rr_last_d = rr_last_q;
    for (int s = 0; s < 2; s++) begin
      elig[s] = (state_q[s] == S_ISSUE) && rnd_valid && !flush;
    end
    gnt = elig;
    if (&elig) gnt = rr_last_q ? 2'b01 : 2'b10;
    if (|gnt) rr_last_d = gnt[1];
  end

  assign sb_in_valid = |gnt;
  assign rnd_ready   = |gnt;
  assign sb_in_src   = gnt[1];
  assign sb_in_idx   = gnt[1] ? cnt_q[1] : (gnt[0] ? cnt_q[0] : 5'd0);

  assign sb_out_valid = tag_v_q[SBOX_LAT-1];
  assign sb_out_src   = tag_src_q[SBOX_LAT-1];
  assign sb_out_idx   = tag_idx_q[SBOX_LAT-1];
  assign retire       = {sb_out_valid & sb_out_src, sb_out_valid & ~sb_out_src};

  assign st_busy = (state_q[0] != S_IDLE);
  assign ks_busy = (state_q[1] != S_IDLE);
  assign st_done = done_q[0];
  assign ks_done = done_q[1];

  always_comb begin
    done_d = 2'b00;
    for (int s = 0; s < 2; s++) begin
      state_d[s] = state_q[s];
      cnt_d[s]   = cnt_q[s];
      infl_d[s]  = infl_q[s] + IW'(gnt[s]) - IW'(retire[s]);
      case (state_q[s])
        S_IDLE: begin
          if (start[s]) begin
            state_d[s] = S_ISSUE;
            cnt_d[s]   = 5'd0;
          end
        end
        S_ISSUE: begin
          if (gnt[s]) begin
            cnt_d[s] = cnt_q[s] + 5'd1;
            if (cnt_q[s] == LAST_IDX[s]) state_d[s] = S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Done is registered, so it lands the cycle after the final retire.
          if (infl_d[s] == '0) begin
            done_d[s]  = 1'b1;
            state_d[s] = S_IDLE;
          end
        end
        default: state_d[s] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < 2; s++) begin
        state_q[s] <= S_IDLE;
        cnt_q[s]   <= 5'd0;
        infl_q[s]  <= '0;
      end
      done_q    <= 2'b00;
      rr_last_q <= 1'b0;
    end else if (flush) begin
      for (int s = 0; s < 2; s++) begin
        state_q[s] <= S_IDLE;
        cnt_q[s]   <= 5'd0;
        infl_q[s]  <= '0;
      end
      done_q    <= 2'b00;
      rr_last_q <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        state_q[s] <= state_d[s];
        cnt_q[s]   <= cnt_d[s];
        infl_q[s]  <= infl_d[s];
      end
      done_q    <= done_d;
      rr_last_q <= rr_last_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SBOX_LAT; i++) begin
        tag_v_q[i]   <= 1'b0;
        tag_src_q[i] <= 1'b0;
        tag_idx_q[i] <= 5'd0;
      end
    end else if (flush) begin
      for (int i = 0; i < SBOX_LAT; i++) begin
        tag_v_q[i]   <= 1'b0;
        tag_src_q[i] <= 1'b0;
        tag_idx_q[i] <= 5'd0;
      end
    end else begin
      tag_v_q[0]   <= sb_in_valid;
      tag_src_q[0] <= sb_in_src;
      tag_idx_q[0] <= sb_in_idx;
      for (int i = 1; i < SBOX_LAT; i++) begin
        tag_v_q[i]   <= tag_v_q[i-1];
        tag_src_q[i] <= tag_src_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_sbox_pipe_sched.sv
// Bench for sbox_pipe_sched: directed scenarios plus random traffic, each cycle
// compared against a queue-based job/in-flight reference model.
module tb_sbox_pipe_sched;
  localparam int LAT = 4;
  localparam int NST = 16;
  localparam int NKS = 4;

  logic       CLK = 1'b0;
  logic       RST, flush, st_start, ks_start, rnd_valid;
  logic       st_busy, st_done, ks_busy, ks_done, rnd_ready;
  logic       sb_in_valid, sb_in_src, sb_out_valid, sb_out_src;
  logic [4:0] sb_in_idx, sb_out_idx;

  sbox_pipe_sched #(.SBOX_LAT(LAT), .ST_BYTES(NST), .KS_BYTES(NKS)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .st_start(st_start), .st_busy(st_busy), .st_done(st_done),
    .ks_start(ks_start), .ks_busy(ks_busy), .ks_done(ks_done),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .sb_in_valid(sb_in_valid), .sb_in_src(sb_in_src), .sb_in_idx(sb_in_idx),
    .sb_out_valid(sb_out_valid), .sb_out_src(sb_out_src), .sb_out_idx(sb_out_idx)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: job progress per source plus a scoreboard of issued tags and due cycles.
  logic [5:0] exp_q[$];
  int         due_q[$];
  int         m_mode[2];
  int         m_next[2];
  logic       m_done[2];
  int         m_pref;
  int         nbytes[2];

  function automatic void model_reset();
    exp_q.delete();
    due_q.delete();
    for (int s = 0; s < 2; s++) begin
      m_mode[s] = 0;
      m_next[s] = 0;
      m_done[s] = 1'b0;
    end
    m_pref = 1;
  endfunction

  function automatic int model_grant();
    bit st_w, ks_w;
    if (RST || flush || !rnd_valid) return -1;
    st_w = (m_mode[0] == 1);
    ks_w = (m_mode[1] == 1);
    if (st_w && ks_w) return m_pref;
    if (st_w) return 0;
    if (ks_w) return 1;
    return -1;
  endfunction

  function automatic logic [18:0] model_out();
    int         g;
    logic       ov;
    logic [5:0] otag;
    logic [4:0] iidx;
    g    = model_grant();
    ov   = 1'b0;
    otag = 6'd0;
    iidx = 5'd0;
    if (exp_q.size() > 0 && due_q[0] == cyc) begin
      ov   = 1'b1;
      otag = exp_q[0];
    end
    if (g >= 0) iidx = 5'(m_next[g]);
    return {m_mode[0] != 0, m_done[0], m_mode[1] != 0, m_done[1],
            g >= 0, g >= 0, g == 1, iidx, ov, otag};
  endfunction

  function automatic logic [18:0] dut_out();
    return {st_busy, st_done, ks_busy, ks_done, rnd_ready, sb_in_valid,
            sb_in_src, sb_in_idx, sb_out_valid, sb_out_src, sb_out_idx};
  endfunction

  function automatic void model_commit();
    int   g, cnt;
    int   old[2];
    logic nd[2];
    g = model_grant();
    if (RST || flush) begin
      model_reset();
      cyc++;
      return;
    end
    if (exp_q.size() > 0 && due_q[0] == cyc) begin
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
    end
    if (g >= 0) begin
      exp_q.push_back({g[0], 5'(m_next[g])});
      due_q.push_back(cyc + LAT);
      m_pref = 1 - g;
    end
    old = m_mode;
    nd  = '{1'b0, 1'b0};
    for (int s = 0; s < 2; s++) begin
      case (old[s])
        0: if ((s == 0 && st_start) || (s == 1 && ks_start)) begin
          m_mode[s] = 1;
          m_next[s] = 0;
        end
        1: if (g == s) begin
          m_next[s]++;
          if (m_next[s] == nbytes[s]) m_mode[s] = 2;
        end
        2: begin
          cnt = 0;
          foreach (exp_q[i]) if (exp_q[i][5] == s[0]) cnt++;
          if (cnt == 0) begin
            nd[s]     = 1'b1;
            m_mode[s] = 0;
          end
        end
        default: ;
      endcase
    end
    m_done = nd;
    cyc++;
  endfunction

  task automatic advance();
    model_commit();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_idle();
    flush     = 1'b0;
    st_start  = 1'b0;
    ks_start  = 1'b0;
    rnd_valid = 1'b1;
  endtask

  always @(negedge CLK) begin
    for (int s = 0; s < 2; s++) begin
      if (int'(dut.infl_q[s]) > LAT) begin
        $display("FAIL inflight_bound src=%0d count=%0d max=%0d", s, dut.infl_q[s], LAT);
        errors++;
      end
    end
  end

  task automatic test_reset();
    bit hit;
    RST = 1'b1;
    drive_idle();
    model_reset();
    repeat (2) begin
      @(negedge CLK);
      checks++;
      if (dut_out() !== 19'd0) begin
        $display("FAIL reset_state got=%h exp=%h", dut_out(), 19'd0);
        errors++;
      end
      advance();
    end
    RST = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      st_start = (k == 0);
      if (m_mode[0] == 1 && m_next[0] == 7) begin
        hit = 1'b1;
        break;
      end
      @(negedge CLK);
      checks++;
      if (dut_out() !== model_out()) begin
        $display("FAIL reset_prejob cyc=%0d got=%h exp=%h", k, dut_out(), model_out());
        errors++;
      end
      advance();
    end
    st_start = 1'b0;
    checks++;
    if (!hit) begin
      $display("FAIL reset_reach_idx7 got=not_reached exp=reached");
      errors++;
    end
    RST = 1'b1;
    model_reset();
    #2;
    checks++;
    if (dut_out() !== 19'd0) begin
      $display("FAIL reset_async got=%h exp=%h", dut_out(), 19'd0);
      errors++;
    end
    repeat (2) advance();
    RST = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge CLK);
      checks += 2;
      if (dut_out() !== model_out()) begin
        $display("FAIL reset_after cyc=%0d got=%h exp=%h", k, dut_out(), model_out());
        errors++;
      end
      if (sb_out_valid !== 1'b0 || st_done !== 1'b0) begin
        $display("FAIL reset_quiet cyc=%0d out_valid=%b st_done=%b exp=0", k, sb_out_valid, st_done);
        errors++;
      end
      advance();
    end
  endtask

  task automatic test_st_alone();
    logic exp_iv, exp_ov;
    for (int t = 0; t < 25; t++) begin
      st_start = (t == 0);
      @(negedge CLK);
      exp_iv = (t >= 1 && t <= NST);
      exp_ov = (t >= 1 + LAT && t <= NST + LAT);
      checks += 4;
      if (dut_out() !== model_out()) begin
        $display("FAIL st_alone_model cyc=%0d got=%h exp=%h", t, dut_out(), model_out());
        errors++;
      end
      if (sb_in_valid !== exp_iv || (exp_iv && sb_in_idx !== 5'(t - 1))) begin
        $display("FAIL st_alone_issue cyc=%0d valid=%b idx=%0d exp_valid=%b exp_idx=%0d",
                 t, sb_in_valid, sb_in_idx, exp_iv, t - 1);
        errors++;
      end
      if (sb_out_valid !== exp_ov || (exp_ov && sb_out_idx !== 5'(t - 1 - LAT))) begin
        $display("FAIL st_alone_retire cyc=%0d valid=%b idx=%0d exp_valid=%b exp_idx=%0d",
                 t, sb_out_valid, sb_out_idx, exp_ov, t - 1 - LAT);
        errors++;
      end
      if (st_done !== (t == NST + LAT + 1)) begin
        $display("FAIL st_alone_done cyc=%0d got=%b exp=%b", t, st_done, t == NST + LAT + 1);
        errors++;
      end
      advance();
    end
    st_start = 1'b0;
  endtask

  task automatic test_both();
    logic [6:0] hist[64];
    int ngr, ks_t, st_t;
    ngr  = 0;
    ks_t = -1;
    st_t = -1;
    for (int t = 0; t < 30; t++) begin
      st_start = (t == 0);
      ks_start = (t == 0);
      @(negedge CLK);
      checks++;
      if (dut_out() !== model_out()) begin
        $display("FAIL both_model cyc=%0d got=%h exp=%h", t, dut_out(), model_out());
        errors++;
      end
      hist[t] = {sb_in_valid, sb_in_src, sb_in_idx};
      if (sb_in_valid) begin
        if (ngr < 8) begin
          checks++;
          if (sb_in_src !== ((ngr % 2) == 0)) begin
            $display("FAIL both_order grant=%0d src=%b exp=%b", ngr, sb_in_src, (ngr % 2) == 0);
            errors++;
          end
        end
        ngr++;
      end
      if (t >= LAT) begin
        checks++;
        if ({sb_out_valid, sb_out_src, sb_out_idx} !== hist[t-LAT]) begin
          $display("FAIL both_tag cyc=%0d got=%h exp=%h", t, {sb_out_valid, sb_out_src, sb_out_idx}, hist[t-LAT]);
          errors++;
        end
      end
      if (ks_done) ks_t = t;
      if (st_done) st_t = t;
      advance();
    end
    st_start = 1'b0;
    ks_start = 1'b0;
    checks += 2;
    if (ks_t != 12) begin
      $display("FAIL both_ks_done cyc=%0d exp=12", ks_t);
      errors++;
    end
    if (st_t != 25) begin
      $display("FAIL both_st_done cyc=%0d exp=25", st_t);
      errors++;
    end
  endtask

  task automatic test_rnd_toggle();
    int nret, ndone;
    nret  = 0;
    ndone = 0;
    for (int t = 0; t < 18; t++) begin
      ks_start  = (t == 0);
      rnd_valid = (t % 2 == 1);
      @(negedge CLK);
      checks += 3;
      if (dut_out() !== model_out()) begin
        $display("FAIL toggle_model cyc=%0d got=%h exp=%h", t, dut_out(), model_out());
        errors++;
      end
      if (rnd_ready !== sb_in_valid) begin
        $display("FAIL toggle_ready cyc=%0d ready=%b valid=%b", t, rnd_ready, sb_in_valid);
        errors++;
      end
      if (sb_in_valid === 1'b1 && !rnd_valid) begin
        $display("FAIL toggle_gate cyc=%0d issue=1 exp=0", t);
        errors++;
      end
      if (sb_out_valid === 1'b1) begin
        checks++;
        if (sb_out_src !== 1'b1 || sb_out_idx !== 5'(nret)) begin
          $display("FAIL toggle_retire cyc=%0d src=%b idx=%0d exp_src=1 exp_idx=%0d", t, sb_out_src, sb_out_idx, nret);
          errors++;
        end
        nret++;
      end
      if (ks_done === 1'b1) ndone++;
      advance();
    end
    ks_start  = 1'b0;
    rnd_valid = 1'b1;
    checks += 2;
    if (nret != NKS) begin
      $display("FAIL toggle_count got=%0d exp=%0d", nret, NKS);
      errors++;
    end
    if (ndone != 1) begin
      $display("FAIL toggle_done got=%0d exp=1", ndone);
      errors++;
    end
  endtask

  task automatic test_flush();
    bit hit;
    hit = 1'b0;
    for (int t = 0; t < 25; t++) begin
      st_start = (t == 0);
      if (m_mode[0] == 1 && m_next[0] == 9) begin
        hit = 1'b1;
        break;
      end
      @(negedge CLK);
      checks++;
      if (dut_out() !== model_out()) begin
        $display("FAIL flush_pre cyc=%0d got=%h exp=%h", t, dut_out(), model_out());
        errors++;
      end
      advance();
    end
    st_start = 1'b0;
    checks++;
    if (!hit) begin
      $display("FAIL flush_reach_idx9 got=not_reached exp=reached");
      errors++;
    end
    flush = 1'b1;
    @(negedge CLK);
    checks++;
    if (dut_out() !== model_out()) begin
      $display("FAIL flush_cycle got=%h exp=%h", dut_out(), model_out());
      errors++;
    end
    advance();
    flush = 1'b0;
    for (int k = 0; k < LAT + 1; k++) begin
      @(negedge CLK);
      checks += 2;
      if (dut_out() !== model_out()) begin
        $display("FAIL flush_after cyc=%0d got=%h exp=%h", k, dut_out(), model_out());
        errors++;
      end
      if (sb_in_valid !== 1'b0 || sb_out_valid !== 1'b0 || st_busy !== 1'b0 || st_done !== 1'b0) begin
        $display("FAIL flush_quiet cyc=%0d in=%b out=%b busy=%b done=%b exp=0000",
                 k, sb_in_valid, sb_out_valid, st_busy, st_done);
        errors++;
      end
      advance();
    end
  endtask

  task automatic test_restart();
    int n1, d1, d2;
    n1 = 0;
    d1 = -1;
    d2 = -1;
    for (int t = 0; t < 60; t++) begin
      st_start = (t == 0) || (t == 5) || (d1 >= 0 && t == d1 + 1);
      @(negedge CLK);
      checks++;
      if (dut_out() !== model_out()) begin
        $display("FAIL restart_model cyc=%0d got=%h exp=%h", t, dut_out(), model_out());
        errors++;
      end
      if (d1 < 0 && sb_in_valid === 1'b1) n1++;
      if (d1 >= 0 && t == d1 + 2) begin
        checks++;
        if (sb_in_valid !== 1'b1 || sb_in_idx !== 5'd0) begin
          $display("FAIL restart_first valid=%b idx=%0d exp_valid=1 exp_idx=0", sb_in_valid, sb_in_idx);
          errors++;
        end
      end
      if (st_done === 1'b1) begin
        if (d1 < 0) d1 = t;
        else if (d2 < 0) d2 = t;
      end
      advance();
    end
    st_start = 1'b0;
    checks += 3;
    if (n1 != NST) begin
      $display("FAIL restart_count got=%0d exp=%0d", n1, NST);
      errors++;
    end
    if (d1 != NST + LAT + 1) begin
      $display("FAIL restart_done1 cyc=%0d exp=%0d", d1, NST + LAT + 1);
      errors++;
    end
    if (d2 != 2 * NST + 2 * LAT + 3) begin
      $display("FAIL restart_done2 cyc=%0d exp=%0d", d2, 2 * NST + 2 * LAT + 3);
      errors++;
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 600; t++) begin
      if (t < 560) begin
        rnd_valid = ($urandom_range(0, 3) != 0);
        st_start  = ($urandom_range(0, 7) == 0);
        ks_start  = ($urandom_range(0, 5) == 0);
        flush     = ($urandom_range(0, 99) == 0);
      end else begin
        drive_idle();
      end
      @(negedge CLK);
      checks++;
      if (dut_out() !== model_out()) begin
        $display("FAIL random_model cyc=%0d got=%h exp=%h", t, dut_out(), model_out());
        errors++;
      end
      advance();
    end
    drive_idle();
  endtask

  initial begin
    nbytes[0] = NST;
    nbytes[1] = NKS;
    test_reset();
    test_st_alone();
    test_both();
    test_rnd_toggle();
    test_flush();
    test_restart();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
